axi4_lite_master_adapter: RTL and testbench
===========================================

AXI4_LITE_MASTER_ADAPTER -- requirements
Module: axi4_lite_master_adapter

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 12: address width of the request port and the AXI4-Lite AW/AR channels.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, legal values 32 or 64: data width.
REQ-003 Parameter AXI_BYTE_COUNT, default AXI_DATA_WIDTH/8: strobe width; shall not be overridden.
REQ-004 aclk  in  1  single clock; all logic on the rising edge.
REQ-005 aresetn  in  1  synchronous, active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake from the RIF-side initiator.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr / req_wdata / req_wstrb / req_prot  in  AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_BYTE_COUNT / 3  request payload.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-010 rsp_rdata / rsp_resp / rsp_write  out  AXI_DATA_WIDTH / 2 / 1  read data, AXI response code, and the direction of the completed request.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 AXI4-Lite master ports, standard meanings: awaddr, awprot, awvalid (out); awready (in); wdata, wstrb, wvalid (out); wready (in); bresp, bvalid (in); bready (out); araddr, arprot, arvalid (out); arready (in); rdata, rresp, rvalid (in); rready (out).

Function
REQ-013 The block shall have one outstanding transaction at most, and shall implement the FSM states IDLE, WR, WB, RA, RR and RSP.
REQ-014 req_ready shall be 1 only in IDLE; on req_valid&req_ready it shall register the full payload and go to WR (req_write=1) or RA (req_write=0).
REQ-015 All AXI and rsp outputs shall be driven from registers; payload outputs shall stay stable while the corresponding valid is high.
REQ-016 WR: awvalid and wvalid shall both rise on the cycle after acceptance; each shall drop on the cycle after its own handshake, independently.
REQ-017 WR handshake ordering: same-cycle AW and W handshakes are legal, and either order is legal; WR shall exit to WB on the edge where the second handshake completes.
REQ-018 WB: bready shall be 1; on bvalid, the block shall capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, and go to RSP.
REQ-019 RA: arvalid=1 until arready; on handshake the block shall go to RR.
REQ-020 RR: rready=1; on rvalid, the block shall capture rdata and rresp, set rsp_write=0, and go to RSP.
REQ-021 bready shall be 0 outside WB and rready shall be 0 outside RR; a bvalid or rvalid in other states shall not be consumed.
REQ-022 RSP: rsp_valid=1 and held with stable data until rsp_ready; on rsp_ready the block shall return to IDLE (req_ready=1 on the next cycle).
REQ-023 Addresses, awprot/arprot (=req_prot) and wstrb shall be passed unmodified; no alignment or strobe checking.
REQ-024 A wstrb of all zeros shall still issue a full write transaction.
REQ-025 Minimum write latency, with all AXI readies and bvalid asserted immediately: accept at T, AW/W at T+1, B at T+2, rsp_valid at T+3.
REQ-026 Minimum read latency: accept at T, AR at T+1, R at T+2, rsp_valid at T+3.
REQ-027 Back-to-back throughput shall be one transaction per 4 cycles minimum.
REQ-028 SLVERR (2'b10) and DECERR (2'b11) shall be forwarded verbatim in rsp_resp; no retry.

Reset
REQ-029 With aresetn=0 at a rising edge, the FSM shall go to IDLE and awvalid, wvalid, arvalid, bready, rready, rsp_valid and busy shall be 0 after that edge.
REQ-030 Reset values of the remaining outputs: req_ready shall be 1 after the edge when reset is released; all payload/response registers shall be 0.
REQ-031 Reset mid-transaction shall abandon the transaction and shall produce no response.

Verification
REQ-032 Write 0x10 data 0xDEADBEEF strb 0xF, all readies high, bresp=OKAY -> AW/W at T+1, rsp_valid at T+3 with rsp_resp=0, rsp_write=1, rsp_rdata=0.
REQ-033 Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, and exactly one B is accepted.
REQ-034 Read 0x20, slave returns rdata=0x12345678 and rresp=SLVERR after 2 wait cycles -> rsp_rdata=0x12345678, rsp_resp=2'b10, rsp_write=0.
REQ-035 rsp_ready held low 5 cycles -> rsp_valid and payload stable, req_ready=0, and no new AXI valid asserted throughout.
REQ-036 aresetn low for 1 cycle while in WB -> bready=0 and busy=0 next cycle, no rsp_valid, and the next request proceeds normally.
REQ-037 Random back-to-back reads and writes against a memory model with random readies -> every response matches the model, and no AXI protocol violation (valid dropped before ready, payload change while valid).

Source files
------------

// File: rtl/axi4_lite_master_adapter.sv
//------------------------------------------------------------------------------
// axi4_lite_master_adapter
//
// Converts single register-interface requests into AXI4-Lite transactions.
// At most one transaction is in flight. A request is accepted in IDLE. A write
// then drives AW and W together and waits for B. A read drives AR and waits
// for R. The AXI response is held on the rsp port until rsp_ready is seen.
//
// Every AXI and rsp output is a register. Payload registers are loaded only at
// request acceptance, so they cannot change while their valid is high.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready high only in IDLE)
//   req_write            1 = write, 0 = read
//   req_addr/req_wdata   request address and write data
//   req_wstrb/req_prot   byte strobes and protection bits, passed through as is
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes)
//   rsp_resp             AXI response code (OKAY/EXOKAY/SLVERR/DECERR)
//   rsp_write            direction of the completed request
//   busy                 high whenever the FSM is not in IDLE
//   aw*/w*/b*/ar*/r*     AXI4-Lite master channels
//------------------------------------------------------------------------------
module axi4_lite_master_adapter #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  // Request side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [AXI_BYTE_COUNT-1:0] req_wstrb,
  input  logic [2:0]                req_prot,

  // Response side
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_write,

  output logic                      busy,

  // AXI4-Lite write address channel
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,

  // AXI4-Lite write data channel
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [AXI_BYTE_COUNT-1:0] wstrb,
  output logic                      wvalid,
  input  logic                      wready,

  // AXI4-Lite write response channel
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,

  // AXI4-Lite read address channel
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,

  // AXI4-Lite read data channel
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // waiting for a request
    WR   = 3'd1,  // AW and W outstanding
    WB   = 3'd2,  // waiting for the write response
    RA   = 3'd3,  // AR outstanding
    RR   = 3'd4,  // waiting for read data
    RSP  = 3'd5   // holding the response for the initiator
  } state_t;

  state_t state;

  // In WR a channel whose valid is already low has completed its handshake.
  // The write phase is over once each channel is either done or completing
  // on this edge, which covers AW-first, W-first and same-cycle completion.
  logic aw_done;
  logic w_done;

  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  // NOTE: every register below is assigned with <= so all of them update
  // together on the edge; a blocking = would let later statements see the
  // new value within the same edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: the payload and response registers are reset too, so the AXI
      // and rsp ports read 0 after reset instead of leftover data.
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      awaddr    <= '0;
      awprot    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arprot    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      rsp_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high in IDLE, so req_valid alone means acceptance.
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_write) begin
              awaddr  <= req_addr;
              awprot  <= req_prot;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR;
            end else begin
              araddr  <= req_addr;
              arprot  <= req_prot;
              arvalid <= 1'b1;
              state   <= RA;
            end
          end
        end

        WR: begin
          // Each valid drops on its own handshake; the two are independent.
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WB;
          end
        end

        WB: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= bresp;
            rsp_write <= 1'b1;
            state     <= RSP;
          end
        end

        RA: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RR;
          end
        end

        RR: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_write <= 1'b0;
            state     <= RSP;
          end
        end

        RSP: begin
          // Response payload is untouched here, so it stays stable until taken.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
//------------------------------------------------------------------------------
// tb_axi4_lite_master_adapter
//
// Drives requests into the adapter and plays an AXI4-Lite slave with a small
// memory. The slave runs either with fixed per-channel delays or with random
// readies and random response delays. Expected responses come from a separate
// word-level memory model that applies each issued write through its byte mask.
// Inputs are driven and outputs sampled on the falling edge.
//------------------------------------------------------------------------------
module tb_axi4_lite_master_adapter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BC = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BC-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [BC-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi4_lite_master_adapter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .busy(busy),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Reset level seen by the DUT at the most recent rising edge.
  logic rst_at_edge = 1'b0;
  always @(posedge aclk) rst_at_edge <= aresetn;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- slave ---
  bit        rnd_mode = 1'b0;
  int        aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] next_resp = 2'b00;

  logic [DW-1:0] smem [16];
  bit        aw_got, w_got, ar_got, b_pend, r_pend;
  bit        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  int        aw_wait, w_wait, ar_wait, b_wait, r_wait, b_lat, r_lat;
  int        b_count = 0, r_count = 0;
  logic [AW-1:0] sv_awaddr, sv_araddr;
  logic [2:0]    sv_awprot, sv_arprot;
  logic [DW-1:0] sv_wdata;
  logic [BC-1:0] sv_wstrb;
  bit        p_awvalid, p_wvalid, p_arvalid;
  logic [AW+2:0] p_aw, p_ar;
  logic [DW+BC-1:0] p_w;

  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    for (int i = 0; i < 16; i++) smem[i] = '0;
    forever begin
      @(negedge aclk);
      if (!rst_at_edge) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
      end else begin
        // A valid left waiting at the last edge must still be up, unchanged.
        if (p_awvalid && !aw_hs) check("aw_hold", 64'({awvalid, awprot, awaddr}), 64'({1'b1, p_aw}));
        if (p_wvalid && !w_hs)   check("w_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, p_w}));
        if (p_arvalid && !ar_hs) check("ar_hold", 64'({arvalid, arprot, araddr}), 64'({1'b1, p_ar}));

        // Handshakes decided last falling edge completed at the rising edge.
        if (aw_hs) begin aw_got = 1; aw_wait = 0; end
        if (w_hs)  begin w_got = 1; w_wait = 0; end
        if (ar_hs) begin ar_got = 1; ar_wait = 0; end
        if (b_hs)  begin bvalid = 1'b0; b_pend = 0; b_count++; end
        if (r_hs)  begin rvalid = 1'b0; r_pend = 0; r_count++; end

        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          for (int b = 0; b < BC; b++)
            if (sv_wstrb[b]) smem[sv_awaddr[5:2]][8*b +: 8] = sv_wdata[8*b +: 8];
          b_pend = 1; b_wait = 0; bresp = next_resp;
          b_lat = rnd_mode ? int'($urandom_range(0, 3)) : b_delay;
        end
        if (ar_got) begin
          ar_got = 0;
          r_pend = 1; r_wait = 0; rdata = smem[sv_araddr[5:2]]; rresp = next_resp;
          r_lat = rnd_mode ? int'($urandom_range(0, 3)) : r_delay;
        end
        if (b_pend && !bvalid) begin
          if (b_wait >= b_lat) bvalid = 1'b1; else b_wait++;
        end
        if (r_pend && !rvalid) begin
          if (r_wait >= r_lat) rvalid = 1'b1; else r_wait++;
        end

        if (rnd_mode) begin
          awready = ($urandom_range(0, 1) == 1);
          wready  = ($urandom_range(0, 1) == 1);
          arready = ($urandom_range(0, 1) == 1);
        end else begin
          awready = awvalid && (aw_wait >= aw_delay);
          wready  = wvalid  && (w_wait  >= w_delay);
          arready = arvalid && (ar_wait >= ar_delay);
          if (awvalid && !awready) aw_wait++;
          if (wvalid && !wready)   w_wait++;
          if (arvalid && !arready) ar_wait++;
        end

        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs  = bvalid && bready;
        r_hs  = rvalid && rready;
        if (aw_hs) begin sv_awaddr = awaddr; sv_awprot = awprot; end
        if (w_hs)  begin sv_wdata = wdata; sv_wstrb = wstrb; end
        if (ar_hs) begin sv_araddr = araddr; sv_arprot = arprot; end

        p_awvalid = awvalid; p_aw = {awprot, awaddr};
        p_wvalid  = wvalid;  p_w  = {wstrb, wdata};
        p_arvalid = arvalid; p_ar = {arprot, araddr};
      end
    end
  end

  // -------------------------------------------------------- reference model --
  logic [DW-1:0] ref_mem [16];
  int last_lat, last_aw_cyc, last_w_cyc;

  // Issues one request, waits for its response (holding rsp_ready low for
  // 'hold' cycles) and compares everything with the reference model.
  // exp_lat < 0 skips the latency comparison.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [BC-1:0] strb, input logic [2:0] prot,
                         input int hold, input int exp_lat);
    int n, c0, aw_c, w_c, ar_c, b0, r0;
    logic [DW-1:0] mask, exp_rdata, r_d;
    logic [1:0] r_r;
    logic r_w;
    b0 = b_count; r0 = r_count;
    for (int b = 0; b < BC; b++) mask[8*b +: 8] = {8{strb[b]}};
    exp_rdata = wr ? '0 : ref_mem[addr[5:2]];
    if (wr) ref_mem[addr[5:2]] = (ref_mem[addr[5:2]] & ~mask) | (data & mask);

    n = 0;
    while (!req_ready && n < 50) begin @(negedge aclk); n++; end
    check("req_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    req_wstrb = strb; req_prot = prot;
    c0 = cyc;
    @(negedge aclk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = DW'($urandom); req_wstrb = BC'($urandom); req_prot = 3'($urandom);
    check("accepted", 64'({req_ready, busy}), 64'(2'b01));

    aw_c = 0; w_c = 0; ar_c = 0; n = 0;
    while (!rsp_valid && n < 300) begin
      if (awvalid) aw_c++;
      if (wvalid) w_c++;
      if (arvalid) ar_c++;
      @(negedge aclk); n++;
    end
    check("rsp_arrived", 64'(rsp_valid), 64'(1));
    last_lat = cyc - c0; last_aw_cyc = aw_c; last_w_cyc = w_c;
    if (exp_lat >= 0) check("latency", 64'(last_lat), 64'(exp_lat));
    check("other_channel", 64'(wr ? ar_c : aw_c + w_c), 64'(0));
    r_d = rsp_rdata; r_r = rsp_resp; r_w = rsp_write;
    check("rsp_payload", 64'({r_w, r_r, r_d}), 64'({wr, next_resp, exp_rdata}));

    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check("rsp_hold", 64'({rsp_valid, req_ready, awvalid, wvalid, arvalid, rsp_write, rsp_resp, rsp_rdata}),
            64'({1'b1, 1'b0, 3'b000, r_w, r_r, r_d}));
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("rsp_taken", 64'({rsp_valid, req_ready, busy}), 64'(3'b010));

    if (wr) begin
      check("aw_w_seen", 64'({sv_awprot, sv_awaddr, sv_wstrb, sv_wdata}), 64'({prot, addr, strb, data}));
      check("one_b", 64'(b_count - b0), 64'(1));
    end else begin
      check("ar_seen", 64'({sv_arprot, sv_araddr}), 64'({prot, addr}));
      check("one_r", 64'(r_count - r0), 64'(1));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // -------------------------------------------------------------- stimulus --
  initial begin
    int n, b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_prot = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_ctl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_rdy", 64'({req_ready, busy, rsp_valid}), 64'(3'b100));
    check("rst_payload", 64'({awaddr, araddr, awprot, arprot, wstrb, rsp_resp, rsp_write}), 64'(0));
    check("rst_data", {wdata, rsp_rdata}, 64'(0));

    // Minimum-latency write, then read it back
    run_txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 3);
    check("wr_aw_cycles", 64'({last_aw_cyc, last_w_cyc}), {32'd1, 32'd1});
    run_txn(1'b0, 12'h010, 32'h0, 4'h0, 3'b010, 0, 3);

    // AW held off three cycles, W immediate
    aw_delay = 3;
    run_txn(1'b1, 12'h014, 32'hA5A5_0F0F, 4'hF, 3'b001, 0, 6);
    check("aw_delay_cycles", 64'({last_aw_cyc, last_w_cyc}), {32'd4, 32'd1});
    aw_delay = 0;

    // W held off two cycles, AW immediate
    w_delay = 2;
    run_txn(1'b1, 12'h018, 32'h0BAD_F00D, 4'h5, 3'b000, 0, 5);
    check("w_delay_cycles", 64'({last_aw_cyc, last_w_cyc}), {32'd1, 32'd3});
    w_delay = 0;

    // Read with SLVERR after two wait cycles
    run_txn(1'b1, 12'h020, 32'h12345678, 4'hF, 3'b000, 0, 3);
    r_delay = 2; next_resp = 2'b10;
    run_txn(1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 0, 5);
    r_delay = 0;

    // Zero-strobe write answered with DECERR, then read back unchanged data
    next_resp = 2'b11;
    run_txn(1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, 3'b111, 0, 3);
    next_resp = 2'b00;
    run_txn(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 0, 3);

    // Response held off for five cycles
    run_txn(1'b0, 12'h014, 32'h0, 4'h0, 3'b101, 5, 3);

    // Reset while waiting for B
    b_delay = 6;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge aclk); n++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h044; req_wdata = 32'hCAFEF00D;
    req_wstrb = 4'hF; req_prot = 3'b000;
    @(negedge aclk);
    req_valid = 1'b0;
    n = 0;
    while (!bready && n < 20) begin @(negedge aclk); n++; end
    check("in_wb", 64'(bready), 64'(1));
    ref_mem[1] = 32'hCAFEF00D;
    b0 = b_count;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    check("rst_in_wb", 64'({bready, busy, rsp_valid, awvalid, wvalid}), 64'(0));
    repeat (4) begin
      @(negedge aclk);
      check("no_rsp_after_rst", 64'({rsp_valid, req_ready}), 64'(2'b01));
    end
    check("no_b_after_rst", 64'(b_count - b0), 64'(0));
    b_delay = 0;
    run_txn(1'b0, 12'h044, 32'h0, 4'h0, 3'b000, 0, 3);

    // Random back-to-back traffic with random readies and delays
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      next_resp = 2'($urandom);
      run_txn(($urandom_range(0, 1) == 1), AW'($urandom) & 12'hFFC, DW'($urandom),
              BC'($urandom), 3'($urandom), int'($urandom_range(0, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
